// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing FSM: fetch, decode, execute, memory and writeback control
// strobes for a RISC-V style datapath, with a sticky illegal-opcode trap and a retire counter.
module multicycle_controller (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  opcode_i,
    input  logic        branch_taken_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        reg_write_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] instret_o
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StTrap      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ClsNone   = 3'd0,
        ClsR      = 3'd1,
        ClsI      = 3'd2,
        ClsLoad   = 3'd3,
        ClsStore  = 3'd4,
        ClsBranch = 3'd5,
        ClsJal    = 3'd6,
        ClsJalr   = 3'd7
    } cls_e;

    localparam logic [6:0] OpcodeR      = 7'b0110011;
    localparam logic [6:0] OpcodeI      = 7'b0010011;
    localparam logic [6:0] OpcodeLoad   = 7'b0000011;
    localparam logic [6:0] OpcodeStore  = 7'b0100011;
    localparam logic [6:0] OpcodeBranch = 7'b1100011;
    localparam logic [6:0] OpcodeJal    = 7'b1101111;
    localparam logic [6:0] OpcodeJalr   = 7'b1100111;

    localparam logic [1:0] PcSrcPlus4  = 2'b00;
    localparam logic [1:0] PcSrcTarget = 2'b01;
    localparam logic [1:0] PcSrcJalr   = 2'b10;

    localparam logic [1:0] WbSelAlu   = 2'b00;
    localparam logic [1:0] WbSelMem   = 2'b01;
    localparam logic [1:0] WbSelPc4   = 2'b10;

    state_e      state_q, state_d;
    cls_e        cls_q, cls_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    // ClsNone doubles as the "unrecognised opcode" result.
    function automatic cls_e decode_opcode(input logic [6:0] op);
        case (op)
            OpcodeR:      decode_opcode = ClsR;
            OpcodeI:      decode_opcode = ClsI;
            OpcodeLoad:   decode_opcode = ClsLoad;
            OpcodeStore:  decode_opcode = ClsStore;
            OpcodeBranch: decode_opcode = ClsBranch;
            OpcodeJal:    decode_opcode = ClsJal;
            OpcodeJalr:   decode_opcode = ClsJalr;
            default:      decode_opcode = ClsNone;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        illegal_d   = illegal_q;
        retire      = 1'b0;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = PcSrcPlus4;
        reg_write_o = 1'b0;
        wb_sel_o    = WbSelAlu;

        case (state_q)
            StFetch: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    pc_src_o   = PcSrcPlus4;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                cls_d = decode_opcode(opcode_i);
                if (cls_d == ClsNone) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                case (cls_q)
                    ClsR, ClsI: begin
                        wb_sel_o = WbSelAlu;
                        state_d  = StWriteback;
                    end
                    ClsLoad, ClsStore: state_d = StMemory;
                    ClsBranch: begin
                        pc_write_o = branch_taken_i;
                        pc_src_o   = PcSrcTarget;
                        retire     = 1'b1;
                        state_d    = StFetch;
                    end
                    ClsJal: begin
                        pc_write_o = 1'b1;
                        pc_src_o   = PcSrcTarget;
                        wb_sel_o   = WbSelPc4;
                        state_d    = StWriteback;
                    end
                    ClsJalr: begin
                        pc_write_o = 1'b1;
                        pc_src_o   = PcSrcJalr;
                        wb_sel_o   = WbSelPc4;
                        state_d    = StWriteback;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMemory: begin
                // Strobes stay up for every wait cycle until the data memory acknowledges.
                dmem_req_o  = 1'b1;
                mem_read_o  = (cls_q == ClsLoad);
                mem_write_o = (cls_q == ClsStore);
                wb_sel_o    = (cls_q == ClsLoad) ? WbSelMem : WbSelAlu;
                if (dmem_ack_i) begin
                    if (cls_q == ClsLoad) begin
                        state_d = StWriteback;
                    end else begin
                        retire  = (cls_q == ClsStore);
                        state_d = StFetch;
                    end
                end
            end
            StWriteback: begin
                reg_write_o = 1'b1;
                case (cls_q)
                    ClsLoad:         wb_sel_o = WbSelMem;
                    ClsJal, ClsJalr: wb_sel_o = WbSelPc4;
                    default:         wb_sel_o = WbSelAlu;
                endcase
                retire  = 1'b1;
                state_d = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase

        // Reset masks every strobe combinationally, not just on the following edge.
        if (rst_i) begin
            imem_req_o  = 1'b0;
            dmem_req_o  = 1'b0;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
            ir_write_o  = 1'b0;
            pc_write_o  = 1'b0;
            pc_src_o    = PcSrcPlus4;
            reg_write_o = 1'b0;
            wb_sel_o    = WbSelAlu;
        end
    end

    assign instret_d = instret_q + {31'd0, retire};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StFetch;
            cls_q     <= ClsNone;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign instret_o = instret_q;

    a_rd_wr_excl : assert property (@(posedge clk_i) !(mem_read_o && mem_write_o));
    a_rf_wr_excl : assert property (@(posedge clk_i) !(reg_write_o && mem_write_o));

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 opcode  input  7  instruction opcode field from the instruction register; sampled in DECODE only.
REQ-005 branch_taken  input  1  branch comparison result from the ALU; sampled in EXECUTE only.
REQ-006 imem_ack  input  1  instruction memory read complete; meaningful only while imem_req=1.
REQ-007 dmem_ack  input  1  data memory access complete; meaningful only while dmem_req=1.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 dmem_req  output  1  data memory request.
REQ-010 mem_read  output  1  data read strobe.
REQ-011 mem_write  output  1  data write strobe.
REQ-012 ir_write  output  1  load instruction register and save old PC.
REQ-013 pc_write  output  1  update PC.
REQ-014 pc_src  output  2  PC source: 00 pc+4, 01 branch/jal target, 10 jalr target.
REQ-015 reg_write  output  1  register file write enable.
REQ-016 wb_sel  output  2  writeback source: 00 ALU, 01 memory, 10 pc+4.
REQ-017 state  output  3  current FSM state encoding.
REQ-018 illegal  output  1  sticky illegal-opcode flag.
REQ-019 instret  output  32  retired-instruction counter.

Function
REQ-020 States SHALL be encoded as FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5; codes 6-7 SHALL go to FETCH on the next edge.
REQ-021 All strobe outputs SHALL be combinational from state and inputs; state, class, illegal and instret SHALL be registered.
REQ-022 FETCH: imem_req=1; without imem_ack, stay with ir_write=pc_write=0; with imem_ack, ir_write=1, pc_write=1, pc_src=00, go to DECODE.
REQ-023 DECODE: classify and register opcode as R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111; go to EXECUTE.
REQ-024 Any other opcode in DECODE SHALL go to TRAP and set illegal=1.
REQ-025 EXECUTE, R/I: go to WRITEBACK, wb_sel=00.
REQ-026 EXECUTE, LOAD/STORE: go to MEMORY.
REQ-027 EXECUTE, BRANCH: pc_write=branch_taken, pc_src=01; go to FETCH; the instruction retires this cycle.
REQ-028 EXECUTE, JAL: pc_write=1, pc_src=01. JALR: pc_write=1, pc_src=10. Both go to WRITEBACK with wb_sel=10.
REQ-029 MEMORY: dmem_req=1; mem_read=1 for LOAD, mem_write=1 for STORE; strobes held until dmem_ack.
REQ-030 MEMORY with dmem_ack: LOAD goes to WRITEBACK with wb_sel=01; STORE goes to FETCH and retires.
REQ-031 WRITEBACK: reg_write=1 for exactly one cycle, wb_sel per class; go to FETCH and retire.
REQ-032 TRAP: all strobes 0; stay until rst; illegal stays 1.
REQ-033 instret SHALL increment by 1 on the retire cycle of each instruction, wrap from 0xFFFFFFFF to 0, and never increment for a trapped instruction.
REQ-034 Latency SHALL be, with ack in the same cycle as its request: BRANCH 3 cycles, STORE 4, R/I/JAL/JALR 4, LOAD 5.
REQ-035 Each wait cycle on imem_ack or dmem_ack SHALL add exactly one cycle.
REQ-036 imem_ack outside FETCH and dmem_ack outside MEMORY SHALL be ignored.
REQ-037 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-038 reg_write and mem_write SHALL never be 1 in the same cycle.

Reset
REQ-039 On rst=1 at a rising edge: state=FETCH, illegal=0, instret=0, class cleared.
REQ-040 Reset SHALL take priority over every transition, including mid-MEMORY with a pending dmem_ack.
REQ-041 While rst=1, all strobes SHALL be 0; imem_req SHALL assert from the first cycle after rst falls.

Verification
REQ-042 R-type add (0110011), acks immediate -> states 0,1,2,4; reg_write=1 in cycle 4, wb_sel=00; instret 0->1.
REQ-043 lw (0000011), dmem_ack delayed 2 cycles -> mem_read=1 for 3 cycles, then WRITEBACK with wb_sel=01; 7 cycles total; instret +1.
REQ-044 beq (1100011) with branch_taken=1, then 0 -> pc_write=1/pc_src=01 in EXECUTE, then pc_write=0; no reg_write either time; instret +2.
REQ-045 jalr (1100111) -> pc_src=10 with pc_write=1 in EXECUTE; WRITEBACK wb_sel=10.
REQ-046 opcode 1111111 -> TRAP (state=5), illegal=1, instret unchanged; rst -> state=0, illegal=0.
REQ-047 sw (0100011), rst asserted in MEMORY together with dmem_ack -> next state=FETCH, mem_write=0, instret=0.
